pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter BOOT_CYCLES, default 4: post-reset cycles with fetch held.
REQ-002 SHALL have parameter MC_TIMEOUT, default 64: max cycles waiting for mc_done.
REQ-003 SHALL have parameter CNT_W, default 16: perf counter width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port PC_sel  in  1  taken branch/jump, registered EX/MEM output.
REQ-007 SHALL have port mc_start  in  1  multi-cycle op present in EX.
REQ-008 SHALL have port mc_done  in  1  multi-cycle result valid this cycle.
REQ-009 SHALL have ports memRead_EX  in  1 and Rdest_EX  in  5  load in EX and its destination.
REQ-010 SHALL have ports rs1_ID, rs2_ID  in  5 each and use_rs1, use_rs2  in  1 each  ID source operands and their validity.
REQ-011 SHALL have port imem_ready  in  1  fetch data valid.
REQ-012 SHALL have outputs pc_en, ifid_en, idex_en, pipe_en, memwb_en  1 each  register enables (pipe_en drives EX/MEM).
REQ-013 SHALL have outputs ifid_flush, idex_flush, exmem_flush  1 each  bubble insert at that register's capture.
REQ-014 SHALL have outputs state  2  (BOOT=00, RUN=01, MC_WAIT=10) and mc_err  1  timeout pulse.
REQ-015 SHALL have outputs stall_cnt, flush_cnt  CNT_W each  perf counters.

Function
REQ-016 SHALL drive the outputs of REQ-012/013 combinationally from state and inputs; default: all enables 1, all flushes 0.
REQ-017 In BOOT: pc_en=ifid_en=0, ifid_flush=1, rest default; boot counter increments; go to RUN once it reaches BOOT_CYCLES-1.
REQ-018 In RUN, priority SHALL be: PC_sel > mc_start > load-use > !imem_ready.
REQ-019 PC_sel=1 in RUN: ifid_flush=idex_flush=exmem_flush=1, all enables 1; stay in RUN.
REQ-020 mc_start=1 in RUN (no PC_sel): pc_en=ifid_en=idex_en=0, exmem_flush=1; mc counter cleared; next state MC_WAIT.
REQ-021 Load-use = memRead_EX & Rdest_EX!=0 & ((use_rs1 & rs1_ID==Rdest_EX) | (use_rs2 & rs2_ID==Rdest_EX)); on hit: pc_en=ifid_en=0, idex_flush=1; exactly one-cycle stall.
REQ-022 imem_ready=0 in RUN (no higher event): pc_en=ifid_en=0 is not used; pc_en=0, ifid_flush=1 only.
REQ-023 In MC_WAIT with mc_done=0: same outputs as REQ-020; mc counter increments.
REQ-024 In MC_WAIT with mc_done=1: default outputs (release); next state RUN.
REQ-025 In MC_WAIT with mc counter = MC_TIMEOUT-1 and mc_done=0: release as REQ-024; mc_err=1 for that cycle only; next state RUN.
REQ-026 PC_sel, mc_start, load-use and imem_ready SHALL be ignored in MC_WAIT and BOOT.
REQ-027 mc_done outside MC_WAIT SHALL be ignored.
REQ-028 mc_done and timeout in the same cycle: release without mc_err.

Reset
REQ-029 rst=1 at a clock edge in any state SHALL force BOOT and clear boot counter, mc counter, stall_cnt, flush_cnt and mc_err.
REQ-030 During rst=1, outputs SHALL be BOOT values (pc_en=0, ifid_flush=1).
REQ-031 rst mid-MC_WAIT SHALL abandon the wait without mc_err.

Configuration
REQ-032 Macro PIPE_CTRL_PERF_EN defined: stall_cnt increments every cycle with pc_en=0 outside BOOT; flush_cnt increments every cycle with PC_sel honoured; both saturate at all-ones.
REQ-033 Macro PIPE_CTRL_PERF_EN undefined: no counter logic; stall_cnt=flush_cnt=0 constant.

Verification
REQ-034 Reset release, imem_ready=1 -> pc_en=0 for 4 cycles, state=01 on cycle 5, pc_en=1.
REQ-035 RUN, memRead_EX=1, Rdest_EX=5, use_rs2=1, rs2_ID=5 -> one cycle pc_en=ifid_en=0, idex_flush=1; next cycle defaults; same with Rdest_EX=0 -> no stall.
REQ-036 RUN, PC_sel=1 and mc_start=1 same cycle -> three flushes asserted, state stays 01.
REQ-037 mc_start, mc_done after 7 cycles -> 7 cycles idex_en=0, exmem_flush=1, release on mc_done, state 01, mc_err=0.
REQ-038 mc_start, mc_done never -> release and mc_err=1 exactly 64 cycles after entry; rst at cycle 30 of a second wait -> BOOT, mc_err stays 0.
REQ-039 PIPE_CTRL_PERF_EN, CNT_W=4, 20 load-use stalls -> stall_cnt=15 saturated.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: boot hold, branch flush, multi-cycle wait, load-use stall.
// Optional perf counters when PIPE_CTRL_PERF_EN is defined; otherwise stall_cnt/flush_cnt tie to 0.
// state   | meaning
// BOOT    | fetch held for BOOT_CYCLES after reset
// RUN     | normal issue, hazards resolved by priority
// MC_WAIT | front end frozen until mc_done or timeout
module pipe_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MC_TIMEOUT  = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_sel,
  input  logic             mc_start,
  input  logic             mc_done,
  input  logic             memRead_EX,
  input  logic [4:0]       Rdest_EX,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             pipe_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int MW = $clog2(MC_TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [MW-1:0] MC_LAST   = MW'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    BOOT    = 2'b00,
    RUN     = 2'b01,
    MC_WAIT = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [MW-1:0] mc_q, mc_d;
  logic          load_use;
  logic          flush_hit;

  assign load_use = memRead_EX && (Rdest_EX != 5'd0) &&
                    ((use_rs1 && (rs1_ID == Rdest_EX)) || (use_rs2 && (rs2_ID == Rdest_EX)));
  assign state = state_q;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    pipe_en     = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mc_err      = 1'b0;
    flush_hit   = 1'b0;
    state_d     = state_q;
    boot_d      = boot_q;
    mc_d        = mc_q;
    case (state_q)
      BOOT: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        if (boot_q == BOOT_LAST) state_d = RUN;
        else                     boot_d  = boot_q + 1'b1;
      end
      RUN: begin
        if (PC_sel) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          flush_hit   = 1'b1;
        end else if (mc_start) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          mc_d        = '0;
          state_d     = MC_WAIT;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!imem_ready) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      MC_WAIT: begin
        // mc_done wins over timeout, so a late-but-valid result never flags an error
        if (mc_done) begin
          state_d = RUN;
        end else if (mc_q == MC_LAST) begin
          mc_err  = 1'b1;
          state_d = RUN;
        end else begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          mc_d        = mc_q + 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b1;
      pipe_en     = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      mc_err      = 1'b0;
      flush_hit   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      boot_q  <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      mc_q    <= mc_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_hit;

  assign stall_hit = !pc_en && (state_q != BOOT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_hit && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_hit && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; ctl bus = {pc_en,ifid_en,idex_en,pipe_en,memwb_en,ifid_flush,idex_flush,exmem_flush}.
module tb_pipe_ctrl;
  logic       clk = 1'b0;
  logic       rst, PC_sel, mc_start, mc_done, memRead_EX, use_rs1, use_rs2, imem_ready;
  logic [4:0] Rdest_EX, rs1_ID, rs2_ID;
  logic       pc_en, ifid_en, idex_en, pipe_en, memwb_en, ifid_flush, idex_flush, exmem_flush;
  logic [1:0] state;
  logic       mc_err;
  logic [3:0] stall_cnt, flush_cnt;
  logic [7:0] ctl;
  int         tests = 0;
  int         fails = 0;

  localparam logic [7:0] C_DEF   = 8'b11111_000;
  localparam logic [7:0] C_BOOT  = 8'b00111_100;
  localparam logic [7:0] C_MC    = 8'b00011_001;
  localparam logic [7:0] C_LU    = 8'b00111_010;
  localparam logic [7:0] C_IMEM  = 8'b01111_100;
  localparam logic [7:0] C_BR    = 8'b11111_111;

  always #5 clk = ~clk;
  assign ctl = {pc_en, ifid_en, idex_en, pipe_en, memwb_en, ifid_flush, idex_flush, exmem_flush};

  pipe_ctrl #(.BOOT_CYCLES(4), .MC_TIMEOUT(64), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .PC_sel(PC_sel), .mc_start(mc_start), .mc_done(mc_done),
    .memRead_EX(memRead_EX), .Rdest_EX(Rdest_EX), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .imem_ready(imem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .pipe_en(pipe_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .state(state), .mc_err(mc_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PC_sel = 0; mc_start = 0; mc_done = 0; memRead_EX = 0; Rdest_EX = 0;
    rs1_ID = 0; rs2_ID = 0; use_rs1 = 0; use_rs2 = 0; imem_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    @(negedge clk);
    tests++;
    if (ctl !== C_BOOT || state !== 2'b00 || mc_err !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: ctl=%b state=%b mc_err=%b, want ctl=%b state=00 mc_err=0", ctl, state, mc_err, C_BOOT);
    end
    tests++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      fails++; $display("FAIL reset_counters: stall=%0d flush=%0d, want 0 0", stall_cnt, flush_cnt);
    end
    tick();
    rst = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests++;
      if (pc_en !== 1'b0 || state !== 2'b00) begin
        fails++; $display("FAIL boot_hold_c%0d: pc_en=%b state=%b, want pc_en=0 state=00", c, pc_en, state);
      end
      tick();
    end
    @(negedge clk);
    tests++;
    if (state !== 2'b01 || pc_en !== 1'b1 || ctl !== C_DEF) begin
      fails++; $display("FAIL boot_release: state=%b ctl=%b, want state=01 ctl=%b", state, ctl, C_DEF);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    memRead_EX = 1; Rdest_EX = 5'd5; use_rs2 = 1; rs2_ID = 5'd5;
    @(negedge clk);
    tests++;
    if (ctl !== C_LU) begin
      fails++; $display("FAIL load_use_rs2: ctl=%b, want %b", ctl, C_LU);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests++;
    if (ctl !== C_DEF || state !== 2'b01) begin
      fails++; $display("FAIL load_use_after: ctl=%b state=%b, want %b 01", ctl, state, C_DEF);
    end
    memRead_EX = 1; Rdest_EX = 5'd0; use_rs2 = 1; rs2_ID = 5'd0;
    @(negedge clk);
    tests++;
    if (ctl !== C_DEF) begin
      fails++; $display("FAIL load_use_r0: ctl=%b, want %b", ctl, C_DEF);
    end
    tick();
    idle_inputs();
    memRead_EX = 1; Rdest_EX = 5'd7; rs1_ID = 5'd7; use_rs1 = 0;
    @(negedge clk);
    tests++;
    if (ctl !== C_DEF) begin
      fails++; $display("FAIL load_use_rs1_unused: ctl=%b, want %b", ctl, C_DEF);
    end
    use_rs1 = 1;
    @(negedge clk);
    tests++;
    if (ctl !== C_LU) begin
      fails++; $display("FAIL load_use_rs1: ctl=%b, want %b", ctl, C_LU);
    end
    memRead_EX = 0;
    @(negedge clk);
    tests++;
    if (ctl !== C_DEF) begin
      fails++; $display("FAIL load_use_no_load: ctl=%b, want %b", ctl, C_DEF);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_imem();
    idle_inputs();
    imem_ready = 0;
    @(negedge clk);
    tests++;
    if (ctl !== C_IMEM) begin
      fails++; $display("FAIL imem_not_ready: ctl=%b, want %b", ctl, C_IMEM);
    end
    memRead_EX = 1; Rdest_EX = 5'd3; use_rs1 = 1; rs1_ID = 5'd3;
    @(negedge clk);
    tests++;
    if (ctl !== C_LU) begin
      fails++; $display("FAIL imem_vs_load_use: ctl=%b, want %b", ctl, C_LU);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch();
    idle_inputs();
    PC_sel = 1; mc_start = 1; imem_ready = 0;
    @(negedge clk);
    tests++;
    if (ctl !== C_BR) begin
      fails++; $display("FAIL branch_flush: ctl=%b, want %b", ctl, C_BR);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests++;
    if (state !== 2'b01 || ctl !== C_DEF) begin
      fails++; $display("FAIL branch_stay_run: state=%b ctl=%b, want 01 %b", state, ctl, C_DEF);
    end
  endtask

  task automatic test_mc_done();
    int stalled;
    stalled = 0;
    idle_inputs();
    mc_start = 1;
    for (int k = 0; k <= 7; k++) begin
      if (k == 1) begin mc_start = 0; PC_sel = 1; imem_ready = 0; end
      if (k == 7) mc_done = 1;
      @(negedge clk);
      if (idex_en === 1'b0 && exmem_flush === 1'b1) stalled++;
      if (k == 3) begin
        tests++;
        if (ctl !== C_MC || state !== 2'b10) begin
          fails++; $display("FAIL mc_wait_outputs: ctl=%b state=%b, want %b 10", ctl, state, C_MC);
        end
      end
      if (k == 7) begin
        tests++;
        if (ctl !== C_DEF || mc_err !== 1'b0) begin
          fails++; $display("FAIL mc_release: ctl=%b mc_err=%b, want %b 0", ctl, mc_err, C_DEF);
        end
      end
      tick();
    end
    idle_inputs();
    tests++;
    if (stalled != 7) begin
      fails++; $display("FAIL mc_stall_cycles: got %0d, want 7", stalled);
    end
    @(negedge clk);
    tests++;
    if (state !== 2'b01 || mc_err !== 1'b0) begin
      fails++; $display("FAIL mc_back_run: state=%b mc_err=%b, want 01 0", state, mc_err);
    end
    mc_done = 1;
    @(negedge clk);
    tests++;
    if (ctl !== C_DEF || state !== 2'b01) begin
      fails++; $display("FAIL mc_done_in_run: ctl=%b state=%b, want %b 01", ctl, state, C_DEF);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    int errs;
    int err_at;
    errs = 0; err_at = -1;
    idle_inputs();
    mc_start = 1;
    for (int k = 0; k <= 66; k++) begin
      if (k == 1) mc_start = 0;
      @(negedge clk);
      if (mc_err === 1'b1) begin errs++; err_at = k; end
      if (k == 63) begin
        tests++;
        if (ctl !== C_MC || state !== 2'b10) begin
          fails++; $display("FAIL timeout_still_wait: ctl=%b state=%b, want %b 10", ctl, state, C_MC);
        end
      end
      if (k == 64) begin
        tests++;
        if (ctl !== C_DEF || mc_err !== 1'b1) begin
          fails++; $display("FAIL timeout_release: ctl=%b mc_err=%b, want %b 1", ctl, mc_err, C_DEF);
        end
      end
      tick();
    end
    tests++;
    if (errs != 1 || err_at != 64) begin
      fails++; $display("FAIL timeout_pulse: count=%0d at=%0d, want 1 at 64", errs, err_at);
    end
    tests++;
    if (state !== 2'b01) begin
      fails++; $display("FAIL timeout_state: state=%b, want 01", state);
    end
    mc_start = 1;
    for (int k = 0; k <= 64; k++) begin
      if (k == 1) mc_start = 0;
      if (k == 64) mc_done = 1;
      @(negedge clk);
      if (k == 64) begin
        tests++;
        if (ctl !== C_DEF || mc_err !== 1'b0) begin
          fails++; $display("FAIL done_and_timeout: ctl=%b mc_err=%b, want %b 0", ctl, mc_err, C_DEF);
        end
      end
      tick();
    end
    idle_inputs();
    errs = 0;
    mc_start = 1;
    for (int k = 0; k <= 30; k++) begin
      if (k == 1) mc_start = 0;
      if (k == 30) rst = 1;
      @(negedge clk);
      if (mc_err === 1'b1) errs++;
      tick();
    end
    @(negedge clk);
    tests++;
    if (state !== 2'b00 || ctl !== C_BOOT) begin
      fails++; $display("FAIL rst_mid_wait: state=%b ctl=%b, want 00 %b", state, ctl, C_BOOT);
    end
    rst = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      @(negedge clk);
      if (mc_err === 1'b1) errs++;
    end
    tests++;
    if (errs != 0 || state !== 2'b01) begin
      fails++; $display("FAIL rst_no_err: mc_err pulses=%0d state=%b, want 0 01", errs, state);
    end
    tick();
  endtask

  task automatic test_perf();
    logic [3:0] exp5, exp20, expf;
`ifdef PIPE_CTRL_PERF_EN
    exp5 = 4'd5; exp20 = 4'd15; expf = 4'd3;
`else
    exp5 = 4'd0; exp20 = 4'd0; expf = 4'd0;
`endif
    do_reset();
    @(negedge clk);
    tests++;
    if (stall_cnt !== 4'd0 || state !== 2'b01) begin
      fails++; $display("FAIL perf_after_boot: stall=%0d state=%b, want 0 01", stall_cnt, state);
    end
    for (int s = 1; s <= 20; s++) begin
      memRead_EX = 1; Rdest_EX = 5'd9; use_rs2 = 1; rs2_ID = 5'd9;
      tick();
      idle_inputs();
      tick();
      if (s == 5) begin
        @(negedge clk);
        tests++;
        if (stall_cnt !== exp5) begin
          fails++; $display("FAIL perf_stall_5: got %0d, want %0d", stall_cnt, exp5);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (stall_cnt !== exp20) begin
      fails++; $display("FAIL perf_stall_sat: got %0d, want %0d", stall_cnt, exp20);
    end
    repeat (3) begin
      PC_sel = 1;
      tick();
      PC_sel = 0;
      tick();
    end
    @(negedge clk);
    tests++;
    if (flush_cnt !== expf) begin
      fails++; $display("FAIL perf_flush: got %0d, want %0d", flush_cnt, expf);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_imem();
    test_branch();
    test_mc_done();
    test_timeout();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
